// File: rtl/node_step_sequencer_if.sv
// -----------------------------------------------------------------------------
// node_step_sequencer_if
// Per-node collision request/result bundle between the node step sequencer
// (master, the initiator) and the collisions engine (slave).
//
// Signals:
//   coll_begin_out                   master->slave  one-cycle request pulse
//   coll_pos_x/y_out, coll_vel_x/y_out master->slave current node state
//   coll_result_in                   slave->master  result-valid pulse
//   coll_new_pos_x/y_in, coll_new_vel_x/y_in slave->master updated node state
//   coll_acc_x/y_in                  slave->master  per-node acceleration
// -----------------------------------------------------------------------------
interface node_step_sequencer_if #(
   parameter int POSITION_SIZE     = 8,
   parameter int VELOCITY_SIZE     = 8,
   parameter int ACCELERATION_SIZE = 3
);
   logic                                coll_begin_out;
   logic signed [POSITION_SIZE-1:0]     coll_pos_x_out;
   logic signed [POSITION_SIZE-1:0]     coll_pos_y_out;
   logic signed [VELOCITY_SIZE-1:0]     coll_vel_x_out;
   logic signed [VELOCITY_SIZE-1:0]     coll_vel_y_out;
   logic                                coll_result_in;
   logic signed [POSITION_SIZE-1:0]     coll_new_pos_x_in;
   logic signed [POSITION_SIZE-1:0]     coll_new_pos_y_in;
   logic signed [VELOCITY_SIZE-1:0]     coll_new_vel_x_in;
   logic signed [VELOCITY_SIZE-1:0]     coll_new_vel_y_in;
   logic signed [ACCELERATION_SIZE-1:0] coll_acc_x_in;
   logic signed [ACCELERATION_SIZE-1:0] coll_acc_y_in;

   modport master (
      output coll_begin_out, coll_pos_x_out, coll_pos_y_out,
             coll_vel_x_out, coll_vel_y_out,
      input  coll_result_in, coll_new_pos_x_in, coll_new_pos_y_in,
             coll_new_vel_x_in, coll_new_vel_y_in, coll_acc_x_in, coll_acc_y_in
   );

   modport slave (
      input  coll_begin_out, coll_pos_x_out, coll_pos_y_out,
             coll_vel_x_out, coll_vel_y_out,
      output coll_result_in, coll_new_pos_x_in, coll_new_pos_y_in,
             coll_new_vel_x_in, coll_new_vel_y_in, coll_acc_x_in, coll_acc_y_in
   );
endinterface

// File: rtl/node_step_sequencer.sv
// -----------------------------------------------------------------------------
// node_step_sequencer
// Owns the car's node state (position/velocity per vertex). On every physics
// step it walks the nodes in order, sends one collision request per node to
// the collisions engine, writes the returned state back and accumulates the
// returned accelerations. A step ends with a one-cycle done pulse.
//
// Ports:
//   clk_in, rst_in            clock, asynchronous active-low reset
//   step_in                   start a step (IDLE only)
//   init_valid_in/init_*_in   write one node's state (IDLE only)
//   coll                      collision request/result bundle (master side)
//   acc_sum_x/y_out           signed acceleration sums of the last step
//   rd_idx_in, rd_pos_x/y_out combinational renderer read port
//   busy_out                  high outside IDLE
//   step_done_out             one-cycle end-of-step pulse
//   timeout_out               sticky: a node timed out in the last step
// -----------------------------------------------------------------------------
module node_step_sequencer #(
   parameter int NUM_NODES         = 8,
   parameter int POSITION_SIZE     = 8,
   parameter int VELOCITY_SIZE     = 8,
   parameter int ACCELERATION_SIZE = 3,
   parameter int TIMEOUT_CYCLES    = 1024,
   localparam int IDX_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1,
   localparam int SUM_W = ACCELERATION_SIZE + IDX_W + 1
) (
   input  logic                            clk_in,
   input  logic                            rst_in,
   input  logic                            step_in,
   input  logic                            init_valid_in,
   input  logic [IDX_W-1:0]                init_idx_in,
   input  logic signed [POSITION_SIZE-1:0] init_pos_x_in,
   input  logic signed [POSITION_SIZE-1:0] init_pos_y_in,
   input  logic signed [VELOCITY_SIZE-1:0] init_vel_x_in,
   input  logic signed [VELOCITY_SIZE-1:0] init_vel_y_in,
   node_step_sequencer_if.master           coll,
   output logic signed [SUM_W-1:0]         acc_sum_x_out,
   output logic signed [SUM_W-1:0]         acc_sum_y_out,
   input  logic [IDX_W-1:0]                rd_idx_in,
   output logic signed [POSITION_SIZE-1:0] rd_pos_x_out,
   output logic signed [POSITION_SIZE-1:0] rd_pos_y_out,
   output logic                            busy_out,
   output logic                            step_done_out,
   output logic                            timeout_out
);

   localparam int  WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam bit  POW2   = ((1 << IDX_W) == NUM_NODES);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_NEXT, S_DONE} state_t;

   state_t                          r_state;
   logic [IDX_W-1:0]                r_idx;
   logic [WAIT_W-1:0]               r_wait_cnt;
   logic signed [POSITION_SIZE-1:0] r_pos_x [NUM_NODES];
   logic signed [POSITION_SIZE-1:0] r_pos_y [NUM_NODES];
   logic signed [VELOCITY_SIZE-1:0] r_vel_x [NUM_NODES];
   logic signed [VELOCITY_SIZE-1:0] r_vel_y [NUM_NODES];
   logic                            r_coll_begin;
   logic signed [POSITION_SIZE-1:0] r_coll_pos_x, r_coll_pos_y;
   logic signed [VELOCITY_SIZE-1:0] r_coll_vel_x, r_coll_vel_y;
   logic signed [SUM_W-1:0]         r_acc_x, r_acc_y;
   logic                            r_step_done;
   logic                            r_timeout;

   logic                            w_init_ok;
   logic                            w_rd_ok;
   logic                            w_init_hit0;
   logic [IDX_W-1:0]                w_next_idx;

   // Sign-extend an engine acceleration to the accumulator width.
   function automatic logic signed [SUM_W-1:0] sext_acc(
      input logic signed [ACCELERATION_SIZE-1:0] a);
      return {{(SUM_W-ACCELERATION_SIZE){a[ACCELERATION_SIZE-1]}}, a};
   endfunction

   // Out-of-range indices only exist when NUM_NODES is not a power of two.
   assign w_init_ok   = POW2 || ({1'b0, init_idx_in} < (IDX_W+1)'(NUM_NODES));
   assign w_rd_ok     = POW2 || ({1'b0, rd_idx_in}   < (IDX_W+1)'(NUM_NODES));
   // An init write to node 0 in the step-start cycle must reach the first request.
   assign w_init_hit0 = init_valid_in && (init_idx_in == '0);
   assign w_next_idx  = r_idx + IDX_W'(1);

   // ---- control FSM and node state ----
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_state      <= S_IDLE;
         r_idx        <= '0;
         r_wait_cnt   <= '0;
         r_coll_begin <= 1'b0;
         r_coll_pos_x <= '0;
         r_coll_pos_y <= '0;
         r_coll_vel_x <= '0;
         r_coll_vel_y <= '0;
         r_acc_x      <= '0;
         r_acc_y      <= '0;
         r_step_done  <= 1'b0;
         r_timeout    <= 1'b0;
         for (int i = 0; i < NUM_NODES; i++) begin
            r_pos_x[i] <= '0;
            r_pos_y[i] <= '0;
            r_vel_x[i] <= '0;
            r_vel_y[i] <= '0;
         end
      end else begin
         r_coll_begin <= 1'b0;
         r_step_done  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (init_valid_in && w_init_ok) begin
                  r_pos_x[init_idx_in] <= init_pos_x_in;
                  r_pos_y[init_idx_in] <= init_pos_y_in;
                  r_vel_x[init_idx_in] <= init_vel_x_in;
                  r_vel_y[init_idx_in] <= init_vel_y_in;
               end
               if (step_in) begin
                  r_state      <= S_ISSUE;
                  r_idx        <= '0;
                  r_acc_x      <= '0;
                  r_acc_y      <= '0;
                  r_timeout    <= 1'b0;
                  r_coll_begin <= 1'b1;
                  r_coll_pos_x <= w_init_hit0 ? init_pos_x_in : r_pos_x[0];
                  r_coll_pos_y <= w_init_hit0 ? init_pos_y_in : r_pos_y[0];
                  r_coll_vel_x <= w_init_hit0 ? init_vel_x_in : r_vel_x[0];
                  r_coll_vel_y <= w_init_hit0 ? init_vel_y_in : r_vel_y[0];
               end
            end
            S_ISSUE: begin
               r_state    <= S_WAIT;
               r_wait_cnt <= '0;
            end
            S_WAIT: begin
               // A result in the final wait cycle takes priority over the timeout.
               if (coll.coll_result_in) begin
                  r_pos_x[r_idx] <= coll.coll_new_pos_x_in;
                  r_pos_y[r_idx] <= coll.coll_new_pos_y_in;
                  r_vel_x[r_idx] <= coll.coll_new_vel_x_in;
                  r_vel_y[r_idx] <= coll.coll_new_vel_y_in;
                  r_acc_x        <= r_acc_x + sext_acc(coll.coll_acc_x_in);
                  r_acc_y        <= r_acc_y + sext_acc(coll.coll_acc_y_in);
                  r_state        <= S_NEXT;
               end else if (r_wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                  r_timeout <= 1'b1;
                  r_state   <= S_NEXT;
               end else begin
                  r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
               end
            end
            S_NEXT: begin
               if (r_idx == IDX_W'(NUM_NODES - 1)) begin
                  r_state     <= S_DONE;
                  r_step_done <= 1'b1;
               end else begin
                  r_idx        <= w_next_idx;
                  r_state      <= S_ISSUE;
                  r_coll_begin <= 1'b1;
                  r_coll_pos_x <= r_pos_x[w_next_idx];
                  r_coll_pos_y <= r_pos_y[w_next_idx];
                  r_coll_vel_x <= r_vel_x[w_next_idx];
                  r_coll_vel_y <= r_vel_y[w_next_idx];
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // ---- outputs ----
   assign coll.coll_begin_out = r_coll_begin;
   assign coll.coll_pos_x_out = r_coll_pos_x;
   assign coll.coll_pos_y_out = r_coll_pos_y;
   assign coll.coll_vel_x_out = r_coll_vel_x;
   assign coll.coll_vel_y_out = r_coll_vel_y;
   assign acc_sum_x_out       = r_acc_x;
   assign acc_sum_y_out       = r_acc_y;
   assign rd_pos_x_out        = w_rd_ok ? r_pos_x[rd_idx_in] : '0;
   assign rd_pos_y_out        = w_rd_ok ? r_pos_y[rd_idx_in] : '0;
   assign busy_out            = (r_state != S_IDLE);
   assign step_done_out       = r_step_done;
   assign timeout_out         = r_timeout;

endmodule

// File: tb/tb_node_step_sequencer.sv
module tb_node_step_sequencer;
   localparam int NN = 8, PS = 8, VS = 8, AS = 3, TO = 16;
   localparam int IW = 3, SW = AS + IW + 1;

   logic                 clk_in = 1'b0;
   logic                 rst_in = 1'b1;
   logic                 step_in = 1'b0;
   logic                 init_valid_in = 1'b0;
   logic [IW-1:0]        init_idx_in = '0;
   logic signed [PS-1:0] init_pos_x_in = '0, init_pos_y_in = '0;
   logic signed [VS-1:0] init_vel_x_in = '0, init_vel_y_in = '0;
   logic signed [SW-1:0] acc_sum_x_out, acc_sum_y_out;
   logic [IW-1:0]        rd_idx_in = '0;
   logic signed [PS-1:0] rd_pos_x_out, rd_pos_y_out;
   logic                 busy_out, step_done_out, timeout_out;

   node_step_sequencer_if #(.POSITION_SIZE(PS), .VELOCITY_SIZE(VS),
                            .ACCELERATION_SIZE(AS)) coll_if ();

   node_step_sequencer #(.NUM_NODES(NN), .POSITION_SIZE(PS), .VELOCITY_SIZE(VS),
                         .ACCELERATION_SIZE(AS), .TIMEOUT_CYCLES(TO)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .step_in(step_in),
      .init_valid_in(init_valid_in), .init_idx_in(init_idx_in),
      .init_pos_x_in(init_pos_x_in), .init_pos_y_in(init_pos_y_in),
      .init_vel_x_in(init_vel_x_in), .init_vel_y_in(init_vel_y_in),
      .coll(coll_if),
      .acc_sum_x_out(acc_sum_x_out), .acc_sum_y_out(acc_sum_y_out),
      .rd_idx_in(rd_idx_in), .rd_pos_x_out(rd_pos_x_out), .rd_pos_y_out(rd_pos_y_out),
      .busy_out(busy_out), .step_done_out(step_done_out), .timeout_out(timeout_out)
   );

   always #5 clk_in = ~clk_in;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic signed [63:0] obs,
                            input logic signed [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Node model
   int m_px[NN], m_py[NN], m_vx[NN], m_vy[NN];

   typedef struct {int px; int py; int vx; int vy;} req_t;
   req_t sb_q[$];

   // Stub engine configuration
   int skip_idx   = -1;
   bit spur_issue = 1'b0;
   int beg_cnt    = 0;
   int done_cnt   = 0;

   always @(negedge clk_in) if (step_done_out === 1'b1) done_cnt++;

   function automatic int wrap_p(input int v);
      logic signed [PS-1:0] t;
      t = v[PS-1:0];
      return int'(t);
   endfunction

   // Stub collisions engine: answers pos+vel, same vel, acc (1,-2), result
   // sampled five edges after the edge that first sees the begin pulse.
   initial begin : stub
      logic signed [PS-1:0] npx, npy;
      logic signed [VS-1:0] nvx, nvy;
      req_t e;
      int   idx;
      coll_if.coll_result_in    = 1'b0;
      coll_if.coll_new_pos_x_in = '0;
      coll_if.coll_new_pos_y_in = '0;
      coll_if.coll_new_vel_x_in = '0;
      coll_if.coll_new_vel_y_in = '0;
      coll_if.coll_acc_x_in     = '0;
      coll_if.coll_acc_y_in     = '0;
      forever begin
         @(posedge clk_in); #1;
         if (coll_if.coll_begin_out === 1'b1) begin
            idx = beg_cnt;
            beg_cnt++;
            check_val("sb_avail", (sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
               e = sb_q.pop_front();
               check_val($sformatf("req_px%0d", idx), coll_if.coll_pos_x_out, e.px);
               check_val($sformatf("req_py%0d", idx), coll_if.coll_pos_y_out, e.py);
               check_val($sformatf("req_vx%0d", idx), coll_if.coll_vel_x_out, e.vx);
               check_val($sformatf("req_vy%0d", idx), coll_if.coll_vel_y_out, e.vy);
            end
            npx = coll_if.coll_pos_x_out + coll_if.coll_vel_x_out;
            npy = coll_if.coll_pos_y_out + coll_if.coll_vel_y_out;
            nvx = coll_if.coll_vel_x_out;
            nvy = coll_if.coll_vel_y_out;
            if (idx != skip_idx) begin
               if (spur_issue) begin
                  coll_if.coll_new_pos_x_in = 8'sd99;
                  coll_if.coll_new_pos_y_in = 8'sd99;
                  coll_if.coll_acc_x_in     = 3'sd3;
                  coll_if.coll_acc_y_in     = 3'sd3;
                  coll_if.coll_result_in    = 1'b1;
                  @(posedge clk_in); #1;
                  coll_if.coll_result_in    = 1'b0;
                  repeat (4) @(posedge clk_in);
               end else begin
                  repeat (5) @(posedge clk_in);
               end
               #1;
               coll_if.coll_new_pos_x_in = npx;
               coll_if.coll_new_pos_y_in = npy;
               coll_if.coll_new_vel_x_in = nvx;
               coll_if.coll_new_vel_y_in = nvy;
               coll_if.coll_acc_x_in     = 3'sd1;
               coll_if.coll_acc_y_in     = -3'sd2;
               coll_if.coll_result_in    = 1'b1;
               @(posedge clk_in); #1;
               coll_if.coll_result_in    = 1'b0;
            end
         end
      end
   end

   task automatic init_node(input int i, input int px, input int py,
                            input int vx, input int vy);
      init_valid_in = 1'b1;
      init_idx_in   = i[IW-1:0];
      init_pos_x_in = px[PS-1:0];
      init_pos_y_in = py[PS-1:0];
      init_vel_x_in = vx[VS-1:0];
      init_vel_y_in = vy[VS-1:0];
      @(posedge clk_in); #1;
      init_valid_in = 1'b0;
      m_px[i] = px; m_py[i] = py; m_vx[i] = vx; m_vy[i] = vy;
   endtask

   task automatic check_nodes(input string tag);
      for (int i = 0; i < NN; i++) begin
         rd_idx_in = i[IW-1:0];
         #1;
         check_val($sformatf("%s_rdx%0d", tag, i), rd_pos_x_out, m_px[i]);
         check_val($sformatf("%s_rdy%0d", tag, i), rd_pos_y_out, m_py[i]);
      end
   endtask

   // Runs one step from IDLE. Optional same-cycle init of node 0, optional
   // busy-time pokes, optional abort by reset during WAIT of node abort_node.
   task automatic run_step(input string tag, input int exp_lat, input bit with_init,
                           input int ipx, input int ipy, input bit poke,
                           input int abort_node);
      int n_resp, cnt, d0;
      bit aborted;
      aborted = 1'b0;
      if (with_init) begin
         init_valid_in = 1'b1;
         init_idx_in   = '0;
         init_pos_x_in = ipx[PS-1:0];
         init_pos_y_in = ipy[PS-1:0];
         init_vel_x_in = m_vx[0][VS-1:0];
         init_vel_y_in = m_vy[0][VS-1:0];
         m_px[0] = ipx; m_py[0] = ipy;
      end
      n_resp = 0;
      for (int i = 0; i < NN; i++) begin
         sb_q.push_back('{m_px[i], m_py[i], m_vx[i], m_vy[i]});
         if (i != skip_idx) begin
            m_px[i] = wrap_p(m_px[i] + m_vx[i]);
            m_py[i] = wrap_p(m_py[i] + m_vy[i]);
            n_resp++;
         end
      end
      d0      = done_cnt;
      beg_cnt = 0;
      step_in = 1'b1;
      cnt     = 1;
      do begin
         @(posedge clk_in); #1;
         step_in       = 1'b0;
         init_valid_in = 1'b0;
         cnt++;
         if (poke && cnt == 12) begin
            check_val({tag, "_busy_mid"}, busy_out, 1);
            step_in       = 1'b1;
            init_valid_in = 1'b1;
            init_idx_in   = 3'd5;
            init_pos_x_in = 8'sd77;
            init_pos_y_in = -8'sd77;
         end
         if (abort_node >= 0 && beg_cnt > abort_node && cnt > 3) aborted = 1'b1;
      end while (step_done_out !== 1'b1 && cnt < 4000 && !aborted);

      if (aborted) begin
         rst_in = 1'b0;
         #1;
         check_val({tag, "_rst_begin"}, coll_if.coll_begin_out, 0);
         check_val({tag, "_rst_busy"}, busy_out, 0);
         check_val({tag, "_rst_done"}, step_done_out, 0);
         check_val({tag, "_rst_acc_x"}, acc_sum_x_out, 0);
         check_val({tag, "_rst_acc_y"}, acc_sum_y_out, 0);
         check_val({tag, "_rst_cpx"}, coll_if.coll_pos_x_out, 0);
         for (int i = 0; i < NN; i++) begin
            m_px[i] = 0; m_py[i] = 0; m_vx[i] = 0; m_vy[i] = 0;
         end
         sb_q.delete();
         repeat (10) @(posedge clk_in);
         check_nodes({tag, "_rst"});
         check_val({tag, "_rst_no_done"}, done_cnt - d0, 0);
         #2;
         rst_in = 1'b1;
         @(posedge clk_in); #1;
         return;
      end

      check_val({tag, "_done_seen"}, step_done_out, 1);
      if (exp_lat > 0) check_val({tag, "_latency"}, cnt, exp_lat);
      repeat (20) @(posedge clk_in);
      #1;
      check_val({tag, "_done_count"}, done_cnt - d0, 1);
      check_val({tag, "_sb_drain"}, sb_q.size(), 0);
      check_val({tag, "_busy_end"}, busy_out, 0);
      check_val({tag, "_acc_x"}, acc_sum_x_out, n_resp);
      check_val({tag, "_acc_y"}, acc_sum_y_out, -2 * n_resp);
      check_val({tag, "_timeout"}, timeout_out, (skip_idx >= 0 && skip_idx < NN) ? 1 : 0);
      check_nodes(tag);
   endtask

   task automatic init_all();
      for (int i = 0; i < NN; i++) init_node(i, i, 2 * i, 1, -1);
   endtask

   initial begin : main
      for (int i = 0; i < NN; i++) begin
         m_px[i] = 0; m_py[i] = 0; m_vx[i] = 0; m_vy[i] = 0;
      end
      #2 rst_in = 1'b0;
      #1;
      check_val("rst0_busy", busy_out, 0);
      check_val("rst0_done", step_done_out, 0);
      check_val("rst0_timeout", timeout_out, 0);
      check_val("rst0_begin", coll_if.coll_begin_out, 0);
      check_val("rst0_acc_x", acc_sum_x_out, 0);
      check_val("rst0_acc_y", acc_sum_y_out, 0);
      repeat (3) @(posedge clk_in);
      #2 rst_in = 1'b1;
      @(posedge clk_in); #1;
      check_nodes("rst0");

      // Basic step
      init_all();
      run_step("basic", 58, 1'b0, 0, 0, 1'b0, -1);
      rd_idx_in = 3'd3; #1;
      check_val("basic_node3_x", rd_pos_x_out, 4);
      check_val("basic_node3_y", rd_pos_y_out, 5);

      // Node 2 never answered
      skip_idx = 2;
      run_step("tmo", 0, 1'b0, 0, 0, 1'b0, -1);
      skip_idx = -1;

      // Init and step in the same cycle; also clears the sticky timeout
      run_step("initstep", 58, 1'b1, -5, 7, 1'b0, -1);

      // step/init pokes while busy
      run_step("poke", 58, 1'b0, 0, 0, 1'b1, -1);

      // Spurious result in IDLE, then in every ISSUE cycle of a step
      coll_if.coll_new_pos_x_in = 8'sd99;
      coll_if.coll_new_pos_y_in = 8'sd99;
      coll_if.coll_acc_x_in     = 3'sd3;
      coll_if.coll_result_in    = 1'b1;
      @(posedge clk_in); #1;
      coll_if.coll_result_in    = 1'b0;
      check_nodes("spur_idle");
      spur_issue = 1'b1;
      run_step("spur_issue", 58, 1'b0, 0, 0, 1'b0, -1);
      spur_issue = 1'b0;

      // Reset during WAIT of node 4, then a normal step
      run_step("abort", 0, 1'b0, 0, 0, 1'b0, 4);
      init_all();
      run_step("after_rst", 58, 1'b0, 0, 0, 1'b0, -1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end
endmodule
